// File: rtl/counter_pkg.sv
// Shared constants and types for the mod-100 counter family (up and down variants).
package counter_pkg;

  localparam int CNT_WIDTH = 7;
  localparam int CNT_LIMIT = 99;
  localparam int CNT_ZERO  = 0;

  // Strobe and clear active levels
  localparam logic STROBE_ON    = 1'b1;
  localparam logic CLEAR_ACTIVE = 1'b0;

  typedef enum logic {
    MODE_COUNT = 1'b0,
    MODE_SET   = 1'b1
  } mode_e;

  typedef enum logic {
    ARMED  = 1'b0,
    BORROW = 1'b1
  } borrow_state_e;

endpackage

// File: rtl/mod_limit_step.sv
// One-step +1/-1 within [ZERO, LIMIT] with wraparound; wrapped flags a boundary crossing.
module mod_limit_step
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int LIMIT = CNT_LIMIT,
  parameter int ZERO  = CNT_ZERO
) (
  input  logic [WIDTH-1:0] value,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] next,
  output logic             wrapped
);

  // One extra bit so out-of-range compares never alias through 2^WIDTH
  localparam logic [WIDTH:0] LIMIT_X = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH:0] ZERO_X  = (WIDTH+1)'(ZERO);
  localparam logic [WIDTH:0] ONE_X   = (WIDTH+1)'(1);

  logic [WIDTH:0] ext;
  logic [WIDTH:0] sum;

  assign ext = {1'b0, value};

  always_comb begin
    next    = value;
    wrapped = 1'b0;
    sum     = ext;
    if (up && !down) begin
      if (ext >= LIMIT_X) begin
        next    = ZERO_X[WIDTH-1:0];
        wrapped = 1'b1;
      end else begin
        sum  = ext + ONE_X;
        next = sum[WIDTH-1:0];
      end
    end else if (down && !up) begin
      if (ext <= ZERO_X) begin
        next    = LIMIT_X[WIDTH-1:0];
        wrapped = 1'b1;
      end else begin
        sum  = ext - ONE_X;
        next = sum[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/down_counter100.sv
// Mod-100 down counter with load, manual SET mode and registered borrow for cascading.
// Define DOWN_COUNTER_STOP_AT_ZERO_EN to hold at zero instead of wrapping (one-shot timer).
module down_counter100
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int LIMIT = CNT_LIMIT,
  parameter int ZERO  = CNT_ZERO
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             mode,
  input  logic             manual_increment,
  input  logic             manual_decrement,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             borrow_out,
  output logic             zero,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] ZERO_V  = WIDTH'(ZERO);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(ZERO + 1);
`ifdef DOWN_COUNTER_STOP_AT_ZERO_EN
  localparam bit STOP_AT_ZERO = 1'b1;
`else
  localparam bit STOP_AT_ZERO = 1'b0;
`endif

  borrow_state_e    state, state_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             step_up, step_down, step_wrapped;
  logic             set_mode;

  assign set_mode     = (mode == MODE_SET);
  assign load_clamped = (load_value > LIMIT_V) ? LIMIT_V : load_value;

  // The same stepper serves manual adjust and the count tick
  always_comb begin
    step_up   = 1'b0;
    step_down = 1'b0;
    if (set_mode) begin
      step_up   = (manual_increment == STROBE_ON);
      step_down = (manual_decrement == STROBE_ON);
    end else begin
      step_down = (count == STROBE_ON);
    end
  end

  mod_limit_step #(
    .WIDTH(WIDTH),
    .LIMIT(LIMIT),
    .ZERO (ZERO)
  ) u_step (
    .value  (out),
    .up     (step_up),
    .down   (step_down),
    .next   (step_val),
    .wrapped(step_wrapped)
  );

  always_comb begin
    out_nxt   = out;
    state_nxt = state;
    if (load == STROBE_ON) begin
      out_nxt   = load_clamped;
      state_nxt = ARMED;
    end else if (set_mode) begin
      out_nxt   = step_val;
      state_nxt = ARMED;
    end else if (count == STROBE_ON) begin
      // Only a tick from ZERO can wrap on the down path
      out_nxt   = (STOP_AT_ZERO && step_wrapped) ? ZERO_V : step_val;
      state_nxt = (out == ONE_V) ? BORROW : ARMED;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_n == CLEAR_ACTIVE) begin
      out   <= ZERO_V;
      state <= ARMED;
    end else begin
      out   <= out_nxt;
      state <= state_nxt;
    end
  end

  assign borrow_out = (state == BORROW);
  assign zero       = (out == ZERO_V);

endmodule
